ov7670_pixel_capture: RTL and testbench

//   Writer side of the 176x144 RGB332 frame buffer that the image processor and the VGA path read.

---
 rtl/ov7670_pixel_capture_pkg.sv | 26 ++
 rtl/ov7670_pixel_capture_rgb565_to_rgb332.sv | 12 +
 rtl/ov7670_pixel_capture.sv | 122 ++++++++++++
 tb/tb_ov7670_pixel_capture.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pixel_capture_pkg.sv
// Frame-buffer geometry and capture FSM encodings shared with the image processor.
// Also provides the RGB565 -> RGB332 pack used by the capture and test-pattern paths.
package ov7670_pixel_capture_pkg;

   localparam int SCREEN_WIDTH  = 176;
   localparam int SCREEN_HEIGHT = 144;
   localparam int PIXEL_COUNT   = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int PIX_ADDR_W    = 15;

   typedef enum logic [1:0] {
      WAIT_BLANK = 2'd0,
      WAIT_START = 2'd1,
      ACTIVE     = 2'd2
   } cap_state_t;

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } byte_phase_t;

   // hi carries R[4:0],G[5:3]; lo carries G[2:0],B[4:0]
   function automatic logic [7:0] pack_rgb332(input logic [7:0] hi, input logic [7:0] lo);
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

endpackage

// File: rtl/ov7670_pixel_capture_rgb565_to_rgb332.sv
// Combinational pack of an RGB565 byte pair into one RGB332 pixel.
module rgb565_to_rgb332
   import ov7670_pixel_capture_pkg::*;
(
   input  logic [7:0] hi_byte,
   input  logic [7:0] lo_byte,
   output logic [7:0] rgb332
);

   assign rgb332 = pack_rgb332(hi_byte, lo_byte);

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 byte-stream capture: packs RGB565 pairs to RGB332 and writes them in raster
// order to the frame buffer, with frame-done and per-frame overflow reporting.
module ov7670_pixel_capture
   import ov7670_pixel_capture_pkg::*;
#(
   parameter int WIDTH  = SCREEN_WIDTH,
   parameter int HEIGHT = SCREEN_HEIGHT,
   parameter int ADDR_W = PIX_ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [7:0]        CAM_DATA,
   input  logic              CAM_HREF,
   input  logic              CAM_VSYNC,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [7:0]        W_DATA,
   output logic              W_EN,
   output logic              FRAME_DONE,
   output logic              OVERFLOW
);

   localparam int XW = $clog2(WIDTH + 1);
   localparam int YW = $clog2(HEIGHT + 1);
   localparam logic [XW-1:0]     X_LIMIT   = XW'(WIDTH);
   localparam logic [YW-1:0]     Y_LIMIT   = YW'(HEIGHT);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

   cap_state_t        state;
   byte_phase_t       phase;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] line_base;
   logic [7:0]        hi;
   logic              href_d;
   logic              vsync_d;
   logic [7:0]        pixel;
   logic              vsync_rise;
   logic              vsync_fall;
   logic              href_fall;

   rgb565_to_rgb332 u_pack (
      .hi_byte (hi),
      .lo_byte (CAM_DATA),
      .rgb332  (pixel)
   );

   assign vsync_rise = !vsync_d && CAM_VSYNC;
   assign vsync_fall = vsync_d && !CAM_VSYNC;
   assign href_fall  = href_d && !CAM_HREF;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= WAIT_BLANK;
         phase      <= FIRST;
         x          <= '0;
         y          <= '0;
         line_base  <= '0;
         hi         <= '0;
         href_d     <= 1'b0;
         vsync_d    <= 1'b0;
         W_ADDR     <= '0;
         W_DATA     <= '0;
         W_EN       <= 1'b0;
         FRAME_DONE <= 1'b0;
         OVERFLOW   <= 1'b0;
      end else begin
         href_d     <= CAM_HREF;
         vsync_d    <= CAM_VSYNC;
         W_EN       <= 1'b0;
         FRAME_DONE <= 1'b0;
         unique case (state)
            WAIT_BLANK: begin
               if (CAM_VSYNC) state <= WAIT_START;
            end
            WAIT_START: begin
               if (vsync_fall) begin
                  state     <= ACTIVE;
                  phase     <= FIRST;
                  x         <= '0;
                  y         <= '0;
                  line_base <= '0;
                  OVERFLOW  <= 1'b0;
               end
            end
            ACTIVE: begin
               // Frame end outranks line end and any byte arriving on the same cycle
               if (vsync_rise) begin
                  FRAME_DONE <= 1'b1;
                  phase      <= FIRST;
                  state      <= WAIT_START;
               end else if (href_fall) begin
                  phase <= FIRST;
                  if (x != '0) begin
                     x <= '0;
                     if (y != Y_LIMIT) begin
                        y         <= y + 1'b1;
                        line_base <= line_base + LINE_STEP;
                     end
                  end
               end else if (CAM_HREF && !CAM_VSYNC) begin
                  if (phase == FIRST) begin
                     hi    <= CAM_DATA;
                     phase <= SECOND;
                  end else begin
                     phase <= FIRST;
                     if (x < X_LIMIT && y < Y_LIMIT) begin
                        W_EN   <= 1'b1;
                        W_DATA <= pixel;
                        W_ADDR <= line_base + ADDR_W'(x);
                        x      <= x + 1'b1;
                     end else begin
                        OVERFLOW <= 1'b1;
                     end
                  end
               end
            end
            default: state <= WAIT_BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture with hand-computed expected writes.
module tb_ov7670_pixel_capture;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  CAM_DATA;
   logic        CAM_HREF;
   logic        CAM_VSYNC;
   logic [14:0] W_ADDR;
   logic [7:0]  W_DATA;
   logic        W_EN;
   logic        FRAME_DONE;
   logic        OVERFLOW;

   int vectors     = 0;
   int miscompares = 0;

   ov7670_pixel_capture #(
      .WIDTH  (176),
      .HEIGHT (144),
      .ADDR_W (15)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .CAM_DATA   (CAM_DATA),
      .CAM_HREF   (CAM_HREF),
      .CAM_VSYNC  (CAM_VSYNC),
      .W_ADDR     (W_ADDR),
      .W_DATA     (W_DATA),
      .W_EN       (W_EN),
      .FRAME_DONE (FRAME_DONE),
      .OVERFLOW   (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int          cyc = 0;
   int          wr_count, seq_err, fd_count;
   logic [14:0] first_addr, last_addr;
   logic [7:0]  last_data;
   logic [14:0] log_addr [4];
   logic [7:0]  log_data [4];
   int          log_cyc  [4];

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (W_EN) begin
         if (wr_count < 4) begin
            log_addr[wr_count] = W_ADDR;
            log_data[wr_count] = W_DATA;
            log_cyc[wr_count]  = cyc;
         end
         if (wr_count == 0) first_addr = W_ADDR;
         else if (32'(W_ADDR) != 32'(last_addr) + 1) seq_err++;
         last_addr = W_ADDR;
         last_data = W_DATA;
         wr_count++;
      end
      if (FRAME_DONE) fd_count++;
   end

   task automatic clear_log();
      wr_count   = 0;
      seq_err    = 0;
      fd_count   = 0;
      first_addr = '0;
      last_addr  = '0;
      last_data  = '0;
      for (int i = 0; i < 4; i++) begin
         log_addr[i] = '0;
         log_data[i] = '0;
         log_cyc[i]  = -1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic put(input logic [7:0] b);
      CAM_HREF = 1'b1;
      CAM_DATA = b;
      tick(1);
   endtask

   task automatic end_line();
      CAM_HREF = 1'b0;
      CAM_DATA = 8'h00;
      tick(2);
   endtask

   task automatic send_line(input int npix, input logic [7:0] hb, input logic [7:0] lb);
      for (int i = 0; i < npix; i++) begin
         put(hb);
         put(lb);
      end
      end_line();
   endtask

   task automatic blank();
      CAM_HREF  = 1'b0;
      CAM_VSYNC = 1'b1;
      tick(3);
      CAM_VSYNC = 1'b0;
      tick(3);
   endtask

   task automatic vsync_up();
      CAM_HREF  = 1'b0;
      CAM_VSYNC = 1'b1;
      tick(3);
   endtask

   int s0, s1, s2;

   initial begin
      RESET = 1'b1; CAM_DATA = 8'h00; CAM_HREF = 1'b0; CAM_VSYNC = 1'b0;
      clear_log();
      tick(3);
      check("rst_w_en",       W_EN,       0);
      check("rst_w_addr",     W_ADDR,     0);
      check("rst_w_data",     W_DATA,     0);
      check("rst_frame_done", FRAME_DONE, 0);
      check("rst_overflow",   OVERFLOW,   0);
      RESET = 1'b0;
      tick(1);

      // bytes before any blanking interval are not captured
      send_line(4, 8'hF8, 8'h00);
      check("preblank_writes", wr_count, 0);

      // colour packing and write latency
      blank();
      clear_log();
      put(8'hF8); put(8'h00); s0 = cyc;
      put(8'h07); put(8'hE0); s1 = cyc;
      put(8'h00); put(8'h1F); s2 = cyc;
      end_line();
      check("pack_cnt",   wr_count,    3);
      check("pack_a0",    log_addr[0], 0);
      check("pack_d0",    log_data[0], 8'hE0);
      check("pack_a1",    log_addr[1], 1);
      check("pack_d1",    log_data[1], 8'h1C);
      check("pack_a2",    log_addr[2], 2);
      check("pack_d2",    log_data[2], 8'h03);
      check("pack_lat0",  log_cyc[0],  s0);
      check("pack_lat1",  log_cyc[1],  s1);
      check("pack_lat2",  log_cyc[2],  s2);
      vsync_up();
      check("pack_fd",    fd_count,    1);
      check("pack_ovf",   OVERFLOW,    0);

      // full frame
      blank();
      clear_log();
      for (int l = 0; l < 144; l++) send_line(176, 8'hA5, 8'h5A);
      vsync_up();
      check("full_cnt",   wr_count,   25344);
      check("full_first", first_addr, 0);
      check("full_last",  last_addr,  25343);
      check("full_seq",   seq_err,    0);
      check("full_data",  last_data,  8'hB7);
      check("full_fd",    fd_count,   1);
      check("full_ovf",   OVERFLOW,   0);

      // oversized lines and frame
      blank();
      clear_log();
      send_line(180, 8'h12, 8'h34);
      check("ovf_line0_cnt",  wr_count,  176);
      check("ovf_line0_last", last_addr, 175);
      check("ovf_set",        OVERFLOW,  1);
      for (int l = 0; l < 142; l++) send_line(1, 8'h12, 8'h34);
      send_line(180, 8'h12, 8'h34);
      check("ovf_row143_last", last_addr, 25343);
      for (int l = 0; l < 6; l++) send_line(180, 8'h12, 8'h34);
      vsync_up();
      check("ovf_cnt",     wr_count,  494);
      check("ovf_last",    last_addr, 25343);
      check("ovf_fd",      fd_count,  1);
      check("ovf_sticky",  OVERFLOW,  1);
      blank();
      check("ovf_cleared", OVERFLOW,  0);

      // odd byte count on a line
      clear_log();
      for (int i = 0; i < 351; i++) put(8'hC3);
      end_line();
      check("odd_cnt",  wr_count,  175);
      check("odd_last", last_addr, 174);
      send_line(1, 8'hF8, 8'h00);
      check("odd_next_addr", last_addr, 176);
      check("odd_next_data", last_data, 8'hE0);
      vsync_up();

      // short frame ending mid-pixel
      blank();
      clear_log();
      for (int l = 0; l < 80; l++) send_line(2, 8'hA5, 8'h5A);
      put(8'h07);
      CAM_VSYNC = 1'b1; CAM_HREF = 1'b1; CAM_DATA = 8'hE0;
      tick(1);
      CAM_HREF = 1'b0;
      tick(2);
      check("short_cnt",  wr_count,  160);
      check("short_last", last_addr, 13905);
      check("short_fd",   fd_count,  1);
      blank();
      clear_log();
      send_line(1, 8'hF8, 8'h00);
      check("short_next_cnt",  wr_count,    1);
      check("short_next_addr", log_addr[0], 0);
      check("short_next_data", log_data[0], 8'hE0);
      vsync_up();

      // reset mid-line
      blank();
      clear_log();
      for (int l = 0; l < 5; l++) send_line(176, 8'hA5, 8'h5A);
      for (int i = 0; i < 120; i++) begin
         put(8'hA5);
         put(8'h5A);
      end
      put(8'hA5);
      check("mid_cnt", wr_count, 1000);
      RESET = 1'b1; CAM_HREF = 1'b0;
      tick(2);
      check("mid_rst_w_en", W_EN,     0);
      check("mid_rst_addr", W_ADDR,   0);
      check("mid_rst_ovf",  OVERFLOW, 0);
      RESET = 1'b0;
      tick(1);
      clear_log();
      send_line(10, 8'hA5, 8'h5A);
      check("mid_no_writes", wr_count, 0);
      blank();
      send_line(1, 8'h00, 8'h1F);
      check("mid_restart_cnt",  wr_count,    1);
      check("mid_restart_addr", log_addr[0], 0);
      check("mid_restart_data", log_data[0], 8'h03);
      vsync_up();
      check("mid_restart_fd",   fd_count,    1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
